// File: rtl/clock_period_meter_pkg.sv
// Shared types and defaults for the clock period meter.
package clock_period_meter_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  localparam int          DEFAULT_WIDTH   = 28;
  localparam logic [27:0] DEFAULT_TIMEOUT = 28'd200000;

endpackage

// File: rtl/clock_period_meter_sync_edge_detect.sv
// Two-flop synchronizer plus history flop; reports the synchronized level
// and a one-cycle pulse on its rising edge.
module clock_period_meter_sync_edge_detect (
  input  logic clock_in,
  input  logic reset,
  input  logic sig_in,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clock_in cycles.
// High-time measurement is built only when CLOCK_PERIOD_METER_DUTY_EN is defined.
//
// state   | meaning
// IDLE    | waiting for the first rising edge to arm the counters
// MEASURE | counting since the last rising edge; next edge reports a result
module clock_period_meter
  import clock_period_meter_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TIMEOUT = WIDTH'(DEFAULT_TIMEOUT)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period_out,
  output logic [WIDTH-1:0] high_out,
  output logic             valid,
  output logic             timeout
);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_next;
  logic [WIDTH-1:0] period_next;
  logic             valid_next;
  logic             timeout_next;
  logic             level;
  logic             rise;
  logic             arm;
  logic             load;
  logic             abandon;
  logic             count;

  clock_period_meter_sync_edge_detect u_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .sig_in   (sig_in),
    .level    (level),
    .rise     (rise)
  );

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      period_out <= '0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      period_out <= period_next;
      valid      <= valid_next;
      timeout    <= timeout_next;
    end
  end

  // A rising edge is checked before the timeout compare, so an edge landing
  // on the terminal count still yields a valid measurement.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    period_next  = period_out;
    valid_next   = 1'b0;
    timeout_next = timeout;
    arm          = 1'b0;
    load         = 1'b0;
    abandon      = 1'b0;
    count        = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          arm        = 1'b1;
          cnt_next   = WIDTH'(1);
          state_next = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          load         = 1'b1;
          period_next  = cnt;
          valid_next   = 1'b1;
          timeout_next = 1'b0;
          cnt_next     = WIDTH'(1);
        end else if (cnt == TIMEOUT) begin
          abandon      = 1'b1;
          timeout_next = 1'b1;
          period_next  = '0;
          state_next   = IDLE;
        end else begin
          count    = 1'b1;
          cnt_next = cnt + WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef CLOCK_PERIOD_METER_DUTY_EN
  logic [WIDTH-1:0] high_cnt;

  always_ff @(posedge clock_in) begin
    if (reset) begin
      high_cnt <= '0;
      high_out <= '0;
    end else begin
      if (arm || load) begin
        high_cnt <= WIDTH'(1);
      end else if (count) begin
        high_cnt <= high_cnt + WIDTH'(level);
      end
      if (load) begin
        high_out <= high_cnt;
      end else if (abandon) begin
        high_out <= '0;
      end
    end
  end
`else
  logic [3:0] unused_duty;

  assign unused_duty = {level, arm, load, count};
  assign high_out    = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// Directed self-checking bench for clock_period_meter (TIMEOUT shortened to 50).
module tb_clock_period_meter;

  localparam int          W  = 28;
  localparam logic [W-1:0] TO = 28'd50;

  logic         clock_in = 1'b0;
  logic         reset;
  logic         sig_in;
  logic [W-1:0] period_out;
  logic [W-1:0] high_out;
  logic         valid;
  logic         timeout;

  int passed = 0;
  int total  = 0;

  always #5 clock_in = ~clock_in;

  clock_period_meter #(
    .WIDTH   (W),
    .TIMEOUT (TO)
  ) dut (
    .clock_in   (clock_in),
    .reset      (reset),
    .sig_in     (sig_in),
    .period_out (period_out),
    .high_out   (high_out),
    .valid      (valid),
    .timeout    (timeout)
  );

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] exp_high(input int h);
`ifdef CLOCK_PERIOD_METER_DUTY_EN
    return W'(h);
`else
    return '0;
`endif
  endfunction

  // One input period: high for h cycles then low; valid is expected on the
  // third cycle after the rise.
  task automatic drive_check(input string tag, input int n, input int h, input int exp_pulses,
                             input logic [W-1:0] exp_period, input logic [W-1:0] exp_hi);
    int           pulses = 0;
    int           pos = 0;
    logic [W-1:0] p = '0;
    logic [W-1:0] hv = '0;
    logic         to = 1'b0;
    for (int i = 1; i <= n; i++) begin
      sig_in = (i <= h);
      tick();
      if (valid === 1'b1) begin
        pulses++;
        pos = i;
        p   = period_out;
        hv  = high_out;
        to  = timeout;
      end
    end
    check({tag, " pulses"}, W'(pulses), W'(exp_pulses));
    if (exp_pulses == 1) begin
      check({tag, " valid_pos"}, W'(pos), W'(3));
      check({tag, " period"}, p, exp_period);
      check({tag, " high"}, hv, exp_hi);
      check({tag, " timeout_at_valid"}, W'(to), W'(0));
    end
  endtask

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sig_in = ~sig_in;
      tick();
      check("reset_outs", period_out | high_out | W'({valid, timeout}), '0);
    end
    sig_in = 1'b0;
    reset  = 1'b0;

    drive_check("arm", 10, 5, 0, '0, '0);
    drive_check("p10_a", 10, 5, 1, 28'd10, exp_high(5));
    drive_check("p10_b", 10, 5, 1, 28'd10, exp_high(5));
    drive_check("p10_c", 10, 5, 1, 28'd10, exp_high(5));

    // Last edge then hold low: load happens on tick 3, timeout 50 cycles later.
    drive_check("p10_last", 5, 5, 1, 28'd10, exp_high(5));
    sig_in = 1'b0;
    repeat (47) tick();
    check("timeout_early", W'(timeout), W'(0));
    tick();
    check("timeout_set", W'(timeout), W'(1));
    check("timeout_period", period_out, '0);
    check("timeout_high", high_out, '0);
    check("timeout_valid", W'(valid), W'(0));

    drive_check("rearm", 20, 8, 0, '0, '0);
    check("timeout_sticky", W'(timeout), W'(1));
    drive_check("after_to", 20, 8, 1, 28'd20, exp_high(8));
    check("timeout_cleared", W'(timeout), W'(0));

    drive_check("p50_first", 50, 5, 1, 28'd20, exp_high(8));
    drive_check("p50_edge", 50, 5, 1, TO, exp_high(5));
    check("edge_wins_timeout", W'(timeout), W'(0));
    drive_check("p51_lead", 51, 5, 1, TO, exp_high(5));
    drive_check("p51_to", 51, 5, 0, '0, '0);
    check("p51_timeout", W'(timeout), W'(1));
    check("p51_period", period_out, '0);

    drive_check("pre_rst_arm", 10, 3, 0, '0, '0);
    drive_check("pre_rst", 10, 3, 1, 28'd10, exp_high(3));

    sig_in = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    check("midrst_period", period_out, '0);
    check("midrst_high", high_out, '0);
    check("midrst_flags", W'({valid, timeout}), '0);
    sig_in = 1'b0;
    tick();
    reset = 1'b0;

    drive_check("post_rst_arm", 10, 3, 0, '0, '0);
    drive_check("post_rst", 10, 3, 1, 28'd10, exp_high(3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
